// File: rtl/serial_add_sched_pkg.sv
// serial_add_sched_pkg: shared FSM state type and requester IDs for serial_add_sched
package serial_add_sched_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;
endpackage

// File: rtl/serial_add_sched_fa.sv
// FullAdder: one-bit full adder, the only arithmetic element of the serial datapath
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  assign sum = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

// File: rtl/serial_add_sched.sv
// serial_add_sched: round-robin scheduler sharing one bit-serial FullAdder between two requesters
module serial_add_sched
  import serial_add_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack0,
  output logic             ack1,
  output logic             busy,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             done,
  output logic             done_id
);
  localparam int CW = $clog2(WIDTH);
  state_t state;
  logic [CW-1:0] cnt;
  logic carry, last_grant, fa_s, fa_c, grant, win;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr;
  always_comb begin
    grant = req0 | req1;
    win = (req0 && req1) ? ~last_grant : (req1 ? REQ1 : REQ0);
  end
  FullAdder u_fa (.a(a_sr[0]), .b(b_sr[0]), .c_in(carry), .sum(fa_s), .c_out(fa_c));
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      cnt <= '0;
      carry <= 1'b0;
      a_sr <= '0;
      b_sr <= '0;
      r_sr <= '0;
      sum <= '0;
      cout <= 1'b0;
      done <= 1'b0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      busy <= 1'b0;
      done_id <= REQ0;
      last_grant <= REQ1;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (grant) begin
          a_sr <= win ? a1 : a0;
          b_sr <= win ? b1 : b0;
          carry <= 1'b0;
          cnt <= '0;
          last_grant <= win;
          done_id <= win;
          ack0 <= (win == REQ0);
          ack1 <= (win == REQ1);
          busy <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          carry <= fa_c;
          r_sr <= {fa_s, r_sr[WIDTH-1:1]};
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            sum <= {fa_s, r_sr[WIDTH-1:1]};
            cout <= fa_c;
            done <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/serial_add_sched.md
# serial_add_sched

Bit-serial adder scheduler that shares a single one-bit FullAdder between two requesters. The block arbitrates requests round-robin, latches the winner's WIDTH-bit operands and sequences the FullAdder through WIDTH bit-cycles with a registered carry. It returns a registered sum, the final carry and the ID of the requester served. It is the controlling wrapper around the counter-plus-FullAdder datapath.

## Interface
- `WIDTH`, default 8: operand/sum width in bits, must be ≥ 2.
- `clock`, in, 1: single clock; all state updates on the rising edge.
- `clear`, in, 1: reset, asynchronous and active-high.
- `req0`, in, 1: requester 0 has operands valid.
- `a0`, in, WIDTH: requester 0 operand A.
- `b0`, in, WIDTH: requester 0 operand B.
- `req1`, in, 1: requester 1 has operands valid.
- `a1`, in, WIDTH: requester 1 operand A.
- `b1`, in, WIDTH: requester 1 operand B.
- `ack0`, out, 1: one-cycle pulse; requester 0 operands captured.
- `ack1`, out, 1: one-cycle pulse; requester 1 operands captured.
- `busy`, out, 1: high in RUN and DONE.
- `sum`, out, WIDTH: (A+B) mod 2^WIDTH; holds its value until the next completion.
- `cout`, out, 1: final carry out of bit WIDTH-1.
- `done`, out, 1: one-cycle pulse; `sum`, `cout` and `done_id` are valid.
- `done_id`, out, 1: requester served by the current or last result.

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - If no `req` is high, stay in IDLE.
  - Otherwise grant one requester:
    - If only one `req` is high, that requester wins.
    - If both are high, the winner is the requester that is not `last_grant`. `last_grant` resets to 1, so requester 0 wins first after reset.
  - On the grant edge:
    - `a_sr` ← winner's A and `b_sr` ← winner's B.
    - carry ← 0, bit counter ← 0.
    - `last_grant` ← winner, `done_id` ← winner.
    - Corresponding `ack` ← 1.
    - Go to RUN.
- **RUN:** each edge performs one bit-cycle:
  - FullAdder inputs are `a_sr[0]`, `b_sr[0]` and carry.
  - carry ← c_out.
  - Result shift register shifts right, with the FullAdder sum bit entering the MSB.
  - `a_sr` and `b_sr` shift right.
  - Counter increments.
  - On the edge where counter == WIDTH-1:
    - Load the completed value into `sum`.
    - `cout` ← c_out.
    - Go to DONE.
- **DONE:** `done` = 1 for this cycle only; next edge goes to IDLE.
- **Request handling:**
  - Requests are ignored in RUN and DONE.
  - A requester holds `req` and its operands until it sees its `ack`. Operands may change from the cycle `ack` is high.
  - A `req` still high after `ack` counts as a new request.
- **Arithmetic:** unsigned. Overflow is reported only through `cout`.
- **Reset (`clear` high), asynchronous and effective at any time, including mid-RUN:**
  - state = IDLE.
  - Counter, carry, shift registers, `sum`, `cout`, `done`, `ack0`, `ack1`, `busy` and `done_id` = 0.
  - `last_grant` = 1.
  - Any operation in progress is discarded and produces no `done`.
  - A requester whose `ack` was lost must keep `req` high. It is re-served from scratch after `clear` falls.

## Timing
- **Grant edge E0:**
  - `ack` and `busy` go high after E0.
  - `ack` goes low after E1.
- **Bit edges:** E1…EWIDTH process bits 0…WIDTH-1.
- **Completion:** `done`, `sum` and `cout` are valid in the cycle after EWIDTH. `done` drops after EWIDTH+1.
- **Next grant:** earliest at EWIDTH+2, giving one operation per WIDTH+2 cycles.
- **Requester latency:** from `req` sampled high in IDLE to `done` is WIDTH+1 cycles.
- **All outputs are registered.** No combinational path from `req`, `a` or `b` to any output.

## Structure
- **Shared package:**
  - FSM state type and encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Requester ID constants: REQ0=1'b0, REQ1=1'b1.
- **Counter width:** $clog2(WIDTH).
- **Sub-module:** instantiate the existing `FullAdder` (ports a, b, c_in, sum, c_out) once as the only arithmetic element.
  - Do not add a parallel adder.
  - The arbiter stays inline; it does not need its own module.

## Test plan
- **Basic add:** WIDTH=8; req0 with a0=8'h3C, b0=8'h0F.
  - `ack0` pulses once.
  - 9 cycles after `req0` is sampled: `done`=1, `sum`=8'h4B, `cout`=0, `done_id`=0.
- **Overflow:** req1 with a1=8'hFF, b1=8'h01.
  - `sum`=8'h00, `cout`=1, `done_id`=1.
- **Simultaneous requests from reset:** req0 and req1 high from reset and held.
  - Grant order is 0,1,0,1.
  - `done` every 10 cycles.
  - `done_id` alternates, and each result is correct for its operands.
- **Clear mid-RUN:** `clear` pulsed after 3 bit-cycles.
  - All outputs go to 0 without waiting for a clock edge; no `done`.
  - After release, with `req0` held, a full fresh operation completes with the correct `sum`.
- **Request during RUN:** req1 raised during requester 0's RUN.
  - `ack1` appears only at the first IDLE edge after requester 0's DONE cycle.
  - `sum` holds requester 0's result until requester 1's `done`.
- **Corner operands:** WIDTH=2 build; exhaustive 16 operand pairs on req0.
  - Every {`cout`,`sum`} equals a+b.
